// File: rtl/sap_microsequencer.sv
// ---------------------------------------------------------------------------
// sap_microsequencer
//
// Instruction sequencer and control-word generator for the 8-bit SAP CPU.
// Every instruction runs a common three-state fetch (T0..T2) and then only as
// many execute states as it needs. The instruction ends on its last useful
// T-state. Conditional jumps, load-immediate and run/pause/single-step
// operation are supported.
//
// Timing model:
//   * The T-state register (stage) advances on posedge clk.
//   * The control word and instr_done are decoded from the new stage and
//     registered on negedge clk. They are therefore stable around the
//     following posedge, where the datapath samples them.
//
// Parameters
//   OPCODE_W  opcode width (4..8). Opcodes with any bit above bit 3 set
//             decode as NOP.
//   EXT_EN    1: LDI/JC/JZ are enabled. 0: those opcodes decode as NOP.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   IR opcode field (OPCODE_W bits), stable from T3 onward
//   flag_c     in   registered ALU carry flag
//   flag_z     in   registered ALU zero flag
//   run        in   1 = free-run; 0 = pause at the next instruction boundary
//   step       in   one-cycle pulse: run one instruction while paused
//   ctrl       out  16-bit control word (bit map in the localparams below)
//   stage      out  current T-state (0..5), 6 = IDLE, 7 = HALT
//   halted     out  1 while in HALT
//   instr_done out  high during the last T-state of each instruction
// ---------------------------------------------------------------------------
module sap_microsequencer #(
    parameter int OPCODE_W = 4,
    parameter bit EXT_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    input  logic                run,
    input  logic                step,
    output logic [15:0]         ctrl,
    output logic [2:0]          stage,
    output logic                halted,
    output logic                instr_done
);

    // -----------------------------------------------------------------------
    // Control word bit positions
    // -----------------------------------------------------------------------
    localparam int B_FLAGS_LOAD      = 15;
    localparam int B_PC_INC          = 14;
    localparam int B_PC_EN           = 13;
    localparam int B_PC_LOAD         = 12;
    localparam int B_MAR_ADDR_LOAD_N = 11;
    localparam int B_MAR_MEM_LOAD_N  = 10;
    localparam int B_RAM_EN_N        = 9;
    localparam int B_RAM_LOAD_N      = 8;
    localparam int B_IR_LOAD_N       = 7;
    localparam int B_IR_EN_N         = 6;
    localparam int B_REGA_LOAD_N     = 5;
    localparam int B_REGA_EN         = 4;
    localparam int B_ADDER_SUB       = 3;
    localparam int B_REGB_EN         = 2;
    localparam int B_REGB_LOAD_N     = 1;
    localparam int B_OUT_LOAD_N      = 0;

    // All active-low strobes deasserted, all active-high strobes low.
    localparam logic [15:0] CTRL_NOP = 16'h0FE3;

    // -----------------------------------------------------------------------
    // Opcodes
    // -----------------------------------------------------------------------
    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_NOP = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;

    // -----------------------------------------------------------------------
    // T-state encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_IDLE = 3'd6,
        ST_HALT = 3'd7
    } stage_t;

    stage_t     stage_reg;
    stage_t     stage_next;
    stage_t     last_stage;

    logic       step_pending_reg;
    logic       step_pending_next;
    logic       cond_c_reg;
    logic       cond_z_reg;

    logic       high_bits_set;
    logic [3:0] op_eff;
    logic       leave_idle;
    logic       enter_t3;

    logic [15:0] ctrl_reg;
    logic [15:0] ctrl_dec;
    logic        done_reg;
    logic        done_dec;

    // -----------------------------------------------------------------------
    // Opcode normalisation: anything outside the implemented set becomes NOP
    // so that the rest of the decoder only ever sees legal 4-bit opcodes.
    // -----------------------------------------------------------------------
    generate
        if (OPCODE_W > 4) begin : g_wide_opcode
            assign high_bits_set = |opcode[OPCODE_W-1:4];
        end else begin : g_narrow_opcode
            assign high_bits_set = 1'b0;
        end
    endgenerate

    always_comb begin
        op_eff = opcode[3:0];
        if (high_bits_set) begin
            op_eff = OP_NOP;
        end else if (opcode[3:0] > OP_JZ) begin
            op_eff = OP_NOP;
        end else if (!EXT_EN && (opcode[3:0] >= OP_LDI)) begin
            op_eff = OP_NOP;
        end
    end

    // Last useful T-state of the current instruction.
    always_comb begin
        last_stage = ST_T2;
        case (op_eff)
            OP_HLT:         last_stage = ST_T3;
            OP_NOP:         last_stage = ST_T2;
            OP_ADD, OP_SUB: last_stage = ST_T5;
            OP_LDA:         last_stage = ST_T4;
            OP_OUT:         last_stage = ST_T3;
            OP_STA:         last_stage = ST_T5;
            OP_JMP:         last_stage = ST_T3;
            OP_LDI:         last_stage = ST_T3;
            OP_JC, OP_JZ:   last_stage = ST_T3;
            default:        last_stage = ST_T2;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        stage_next = ST_IDLE;
        case (stage_reg)
            ST_IDLE: begin
                stage_next = (run || step_pending_reg) ? ST_T0 : ST_IDLE;
            end
            ST_HALT: begin
                // Only rst_n leaves HALT.
                stage_next = ST_HALT;
            end
            ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5: begin
                if (stage_reg == last_stage) begin
                    if (op_eff == OP_HLT) begin
                        stage_next = ST_HALT;
                    end else begin
                        stage_next = run ? ST_T0 : ST_IDLE;
                    end
                end else begin
                    case (stage_reg)
                        ST_T0:   stage_next = ST_T1;
                        ST_T1:   stage_next = ST_T2;
                        ST_T2:   stage_next = ST_T3;
                        ST_T3:   stage_next = ST_T4;
                        ST_T4:   stage_next = ST_T5;
                        default: stage_next = ST_IDLE;
                    endcase
                end
            end
            default: stage_next = ST_IDLE;
        endcase
    end

    assign leave_idle = (stage_reg == ST_IDLE) && (stage_stage_is_t0(stage_next));
    assign enter_t3   = (stage_reg == ST_T2) && (stage_next == ST_T3);

    // A step arriving in the same cycle the sequencer leaves IDLE is kept for
    // the next boundary instead of being lost. Steps are ignored in HALT.
    always_comb begin
        step_pending_next = leave_idle ? 1'b0 : step_pending_reg;
        if (step && (stage_reg != ST_HALT)) begin
            step_pending_next = 1'b1;
        end
    end

    function automatic logic stage_stage_is_t0(input stage_t s);
        return s == ST_T0;
    endfunction

    // -----------------------------------------------------------------------
    // Stage register and flag capture (posedge)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg        <= ST_IDLE;
            step_pending_reg <= 1'b0;
            cond_c_reg       <= 1'b0;
            cond_z_reg       <= 1'b0;
        end else begin
            stage_reg        <= stage_next;
            step_pending_reg <= step_pending_next;
            // The jump condition is the flag value at the edge entering T3;
            // later flag changes must not affect a jump already in progress.
            if (enter_t3) begin
                cond_c_reg <= flag_c;
                cond_z_reg <= flag_z;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control-word decode from the current stage
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl_dec = CTRL_NOP;
        done_dec = 1'b0;
        case (stage_reg)
            ST_T0: begin
                ctrl_dec[B_PC_EN]           = 1'b1;
                ctrl_dec[B_MAR_ADDR_LOAD_N] = 1'b0;
            end
            ST_T1: begin
                // HLT must leave the PC pointing at itself.
                if (op_eff != OP_HLT) begin
                    ctrl_dec[B_PC_INC] = 1'b1;
                end
            end
            ST_T2: begin
                ctrl_dec[B_RAM_EN_N]  = 1'b0;
                ctrl_dec[B_IR_LOAD_N] = 1'b0;
            end
            ST_T3: begin
                case (op_eff)
                    OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
                        ctrl_dec[B_IR_EN_N]         = 1'b0;
                        ctrl_dec[B_MAR_ADDR_LOAD_N] = 1'b0;
                    end
                    OP_OUT: begin
                        ctrl_dec[B_REGA_EN]    = 1'b1;
                        ctrl_dec[B_OUT_LOAD_N] = 1'b0;
                    end
                    OP_JMP: begin
                        ctrl_dec[B_IR_EN_N]  = 1'b0;
                        ctrl_dec[B_PC_LOAD]  = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl_dec[B_IR_EN_N]     = 1'b0;
                        ctrl_dec[B_REGA_LOAD_N] = 1'b0;
                    end
                    OP_JC: begin
                        ctrl_dec[B_IR_EN_N] = 1'b0;
                        ctrl_dec[B_PC_LOAD] = cond_c_reg;
                    end
                    OP_JZ: begin
                        ctrl_dec[B_IR_EN_N] = 1'b0;
                        ctrl_dec[B_PC_LOAD] = cond_z_reg;
                    end
                    default: ctrl_dec = CTRL_NOP;
                endcase
            end
            ST_T4: begin
                case (op_eff)
                    OP_ADD, OP_SUB: begin
                        ctrl_dec[B_RAM_EN_N]    = 1'b0;
                        ctrl_dec[B_REGB_LOAD_N] = 1'b0;
                    end
                    OP_LDA: begin
                        ctrl_dec[B_RAM_EN_N]    = 1'b0;
                        ctrl_dec[B_REGA_LOAD_N] = 1'b0;
                    end
                    OP_STA: begin
                        ctrl_dec[B_REGA_EN]        = 1'b1;
                        ctrl_dec[B_MAR_MEM_LOAD_N] = 1'b0;
                    end
                    default: ctrl_dec = CTRL_NOP;
                endcase
            end
            ST_T5: begin
                case (op_eff)
                    OP_ADD, OP_SUB: begin
                        ctrl_dec[B_REGB_EN]     = 1'b1;
                        ctrl_dec[B_REGA_LOAD_N] = 1'b0;
                        ctrl_dec[B_FLAGS_LOAD]  = 1'b1;
                        ctrl_dec[B_ADDER_SUB]   = (op_eff == OP_SUB);
                    end
                    OP_STA: begin
                        ctrl_dec[B_RAM_LOAD_N] = 1'b0;
                    end
                    default: ctrl_dec = CTRL_NOP;
                endcase
            end
            default: ctrl_dec = CTRL_NOP;
        endcase

        if ((stage_reg <= ST_T5) && (stage_reg == last_stage)) begin
            done_dec = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output register (negedge): holds the word steady across the posedge
    // where the datapath consumes it.
    // -----------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= CTRL_NOP;
            done_reg <= 1'b0;
        end else begin
            ctrl_reg <= ctrl_dec;
            done_reg <= done_dec;
        end
    end

    assign ctrl       = ctrl_reg;
    assign instr_done = done_reg;
    assign stage      = stage_reg;
    assign halted     = (stage_reg == ST_HALT);

endmodule

// File: tb/tb_sap_microsequencer.sv
// ---------------------------------------------------------------------------
// tb_sap_microsequencer
//
// Drives two sequencers from the same stimulus: one with the extended
// instructions enabled and one with them disabled. A behavioural model keeps
// the expected T-state of each, derived from instruction lengths and the
// run/step/halt rules, and a compare process checks stage, ctrl, instr_done
// and halted every cycle. Directed literal checks pin the model to
// hand-computed control words.
// ---------------------------------------------------------------------------
module tb_sap_microsequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'h1;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;

    logic [15:0] ctrl_a, ctrl_b;
    logic [2:0]  stage_a, stage_b;
    logic        halted_a, halted_b;
    logic        done_a, done_b;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    sap_microsequencer #(.OPCODE_W(4), .EXT_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .run(run), .step(step), .ctrl(ctrl_a), .stage(stage_a), .halted(halted_a),
        .instr_done(done_a)
    );

    sap_microsequencer #(.OPCODE_W(4), .EXT_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .run(run), .step(step), .ctrl(ctrl_b), .stage(stage_b), .halted(halted_b),
        .instr_done(done_b)
    );

    // ---------------------------------------------------------------- model
    // Effective instruction number after unimplemented opcodes fold to NOP.
    function automatic int eff_op(input int op, input bit ext);
        if (op > 10) return 1;
        if (!ext && op >= 8) return 1;
        return op;
    endfunction

    // Number of the last T-state for each instruction.
    function automatic int last_t(input int e);
        case (e)
            0:       return 3;
            2, 3, 6: return 5;
            4:       return 4;
            5, 7, 8, 9, 10: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int next_t(input int st, input int e, input bit r, input bit pend);
        if (st == 7) return 7;
        if (st == 6) return (r || pend) ? 0 : 6;
        if (st == last_t(e)) return (e == 0) ? 7 : (r ? 0 : 6);
        return st + 1;
    endfunction

    // Control word built from the named strobes.
    function automatic logic [15:0] ctrl_exp(input int e, input int t, input bit take);
        logic [15:0] w;
        w = 16'h0FE3;
        case (t)
            0: begin w[13] = 1'b1; w[11] = 1'b0; end
            1: if (e != 0) w[14] = 1'b1;
            2: begin w[9] = 1'b0; w[7] = 1'b0; end
            3: begin
                if (e inside {2, 3, 4, 6}) begin w[6] = 1'b0; w[11] = 1'b0; end
                if (e == 5) begin w[4] = 1'b1; w[0] = 1'b0; end
                if (e == 7) begin w[6] = 1'b0; w[12] = 1'b1; end
                if (e == 8) begin w[6] = 1'b0; w[5] = 1'b0; end
                if (e == 9 || e == 10) begin w[6] = 1'b0; w[12] = take; end
            end
            4: begin
                if (e == 2 || e == 3) begin w[9] = 1'b0; w[1] = 1'b0; end
                if (e == 4) begin w[9] = 1'b0; w[5] = 1'b0; end
                if (e == 6) begin w[4] = 1'b1; w[10] = 1'b0; end
            end
            5: begin
                if (e == 2 || e == 3) begin
                    w[2] = 1'b1; w[5] = 1'b0; w[15] = 1'b1; w[3] = (e == 3);
                end
                if (e == 6) w[8] = 1'b0;
            end
            default: w = 16'h0FE3;
        endcase
        return w;
    endfunction

    int m_stage [2] = '{6, 6};
    bit m_pend  [2] = '{1'b0, 1'b0};
    bit m_take  [2] = '{1'b0, 1'b0};
    int m_op = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_stage[k] <= 6;
                m_pend[k]  <= 1'b0;
                m_take[k]  <= 1'b0;
            end
        end else begin
            m_op <= int'(opcode);
            for (int k = 0; k < 2; k++) begin
                m_stage[k] <= next_t(m_stage[k], eff_op(int'(opcode), k == 0), run, m_pend[k]);
                m_pend[k]  <= ((m_stage[k] == 6 && (run || m_pend[k])) ? 1'b0 : m_pend[k])
                              | (step && m_stage[k] != 7);
                if (m_stage[k] == 2 &&
                    next_t(2, eff_op(int'(opcode), k == 0), run, m_pend[k]) == 3) begin
                    m_take[k] <= (eff_op(int'(opcode), k == 0) == 9) ? flag_c :
                                 (eff_op(int'(opcode), k == 0) == 10) ? flag_z : 1'b0;
                end
            end
        end
    end

    task automatic cmp(input string name, input int k, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d got %h expected %h", name, k, cycle, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int e, st;
                st = m_stage[k];
                e  = eff_op(m_op, k == 0);
                cmp("stage", k, (k == 0) ? int'(stage_a) : int'(stage_b), st);
                cmp("ctrl", k, (k == 0) ? int'(ctrl_a) : int'(ctrl_b),
                    int'(ctrl_exp(e, st, m_take[k])));
                cmp("instr_done", k, (k == 0) ? int'(done_a) : int'(done_b),
                    (st <= 5 && st == last_t(e)) ? 1 : 0);
                cmp("halted", k, (k == 0) ? int'(halted_a) : int'(halted_b),
                    (st == 7) ? 1 : 0);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL lit_%s got %h expected %h", name, got, exp);
        end
        $display("lit %-14s got %h expected %h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_stage(input int s);
        for (int i = 0; i < 40; i++) begin
            if (int'(stage_a) == s) return;
            tick(1);
        end
        checks++;
        errors++;
        $display("FAIL wait_stage timeout got %0d expected %0d", stage_a, s);
    endtask

    int nop_seq [6] = '{0, 1, 2, 0, 1, 2};
    int misc_ops [6] = '{10, 5, 7, 8, 11, 15};

    initial begin
        // Reset state
        tick(2);
        chk_en = 1'b1;
        lit("rst_stage", stage_a, 6);
        lit("rst_ctrl", ctrl_a, 16'h0FE3);
        lit("rst_halted", halted_a, 0);
        lit("rst_done", done_a, 0);

        // Free-running NOPs
        run = 1'b1;
        opcode = 4'h1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            lit("nop_stage", stage_a, nop_seq[i]);
            lit("nop_done", done_a, (nop_seq[i] == 2) ? 1 : 0);
            if (i == 0) lit("nop_t0_ctrl", ctrl_a, 16'h27E3);
        end

        // ADD / SUB / LDA / STA
        wait_stage(0); opcode = 4'h2;
        wait_stage(5); lit("add_t5_ctrl", ctrl_a, 16'h8FC7);
        wait_stage(0); opcode = 4'h3;
        wait_stage(5); lit("sub_t5_ctrl", ctrl_a, 16'h8FCF);
        wait_stage(0); opcode = 4'h4;
        wait_stage(4); lit("lda_t4_ctrl", ctrl_a, 16'h0DC3);
        lit("lda_t4_done", done_a, 1);
        tick(1); lit("lda_next", stage_a, 0);
        opcode = 4'h6;
        wait_stage(5); lit("sta_t5_ctrl", ctrl_a, 16'h0EE3);

        // Conditional jumps
        wait_stage(0); opcode = 4'h9; flag_c = 1'b0;
        wait_stage(3); lit("jc_nt_ctrl", ctrl_a, 16'h0FA3);
        tick(1); lit("jc_nt_next", stage_a, 0);
        flag_c = 1'b1;
        wait_stage(3); lit("jc_t_ctrl", ctrl_a, 16'h1FA3);
        flag_c = 1'b0;
        tick(1); lit("jc_t_next", stage_a, 0);
        flag_z = 1'b1;
        foreach (misc_ops[i]) begin
            wait_stage(0);
            opcode = 4'(misc_ops[i]);
            tick(1);
        end
        wait_stage(0);
        flag_z = 1'b0;

        // Reset mid-instruction, then LDI on both variants
        opcode = 4'h2;
        wait_stage(4);
        rst_n = 1'b0;
        #1;
        lit("abort_stage", stage_a, 6);
        lit("abort_ctrl", ctrl_a, 16'h0FE3);
        opcode = 4'h8;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        lit("ldi_ext0_stage", stage_b, 2);
        lit("ldi_ext0_done", done_b, 1);
        tick(1);
        lit("ldi_ext0_next", stage_b, 0);
        lit("ldi_t3_ctrl", ctrl_a, 16'h0F83);

        // Pause mid-ADD, then single step
        wait_stage(0); opcode = 4'h2;
        wait_stage(3); run = 1'b0;
        wait_stage(6); lit("pause_stage", stage_a, 6);
        tick(4); lit("pause_hold", stage_a, 6);
        step = 1'b1; tick(1); step = 1'b0;
        wait_stage(5); lit("step_done", done_a, 1);
        tick(1); lit("step_idle", stage_a, 6);
        tick(4); lit("step_hold", stage_a, 6);

        // HLT
        opcode = 4'h0; run = 1'b1;
        wait_stage(1); lit("hlt_t1_ctrl", ctrl_a, 16'h0FE3);
        wait_stage(3); lit("hlt_t3_done", done_a, 1);
        tick(1);
        lit("hlt_stage", stage_a, 7);
        lit("hlt_halted", halted_a, 1);
        lit("hlt_done", done_a, 0);
        for (int i = 0; i < 20; i++) begin
            run  = i[0];
            step = i[1];
            tick(1);
        end
        step = 1'b0;
        lit("hlt_hold_stage", stage_a, 7);
        lit("hlt_hold_halted", halted_a, 1);
        rst_n = 1'b0;
        #1;
        lit("hlt_rst_halted", halted_a, 0);
        lit("hlt_rst_stage", stage_a, 6);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
